// File: rtl/apb_cipher_bridge.sv
// APB front end for a block cipher engine: packs 32-bit writes into blocks, issues them under
// output-FIFO credit, and unpacks results for reading. Optional interrupt logic: APB_BRIDGE_IRQ_EN.
module apb_cipher_bridge #(
  parameter int unsigned BLOCK_W   = 64,
  parameter int unsigned IN_DEPTH  = 4,
  parameter int unsigned OUT_DEPTH = 4,
  parameter int unsigned MODE_W    = 3
) (
  input  logic                PCLK,
  input  logic                PRESET,
  input  logic [2:0]          PADDR,
  input  logic                PSEL,
  input  logic                PENABLE,
  input  logic                PWRITE,
  input  logic [31:0]         PWDATA,
  output logic                PREADY,
  output logic [31:0]         PRDATA,
  output logic                PSLVERR,
  output logic                eng_in_valid,
  input  logic                eng_in_ready,
  output logic [BLOCK_W-1:0]  eng_in_data,
  output logic [MODE_W-1:0]   eng_in_mode,
  input  logic                eng_out_valid,
  input  logic [BLOCK_W-1:0]  eng_out_data
`ifdef APB_BRIDGE_IRQ_EN
  ,
  output logic                irq
`endif
);

  localparam int unsigned WORDS = BLOCK_W / 32;
  localparam int unsigned CW    = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam int unsigned IAW   = (IN_DEPTH > 1) ? $clog2(IN_DEPTH) : 1;
  localparam int unsigned OAW   = (OUT_DEPTH > 1) ? $clog2(OUT_DEPTH) : 1;
  localparam int unsigned LW    = 8;
  localparam int unsigned IEW   = BLOCK_W + MODE_W;

  localparam logic [2:0] A_DIN   = 3'd0;
  localparam logic [2:0] A_DOUT  = 3'd1;
  localparam logic [2:0] A_CTRL  = 3'd2;
  localparam logic [2:0] A_STAT  = 3'd3;
  localparam logic [2:0] A_IEN   = 3'd4;
  localparam logic [2:0] A_ISTAT = 3'd5;

  logic [IEW-1:0]     r_in_mem  [IN_DEPTH];
  logic [BLOCK_W-1:0] r_out_mem [OUT_DEPTH];
  logic [IAW-1:0]     r_in_wr, r_in_rd;
  logic [OAW-1:0]     r_out_wr, r_out_rd;
  logic [LW-1:0]      r_in_level, r_out_level, r_inflight;
  logic [CW-1:0]      r_pack_cnt, r_unpack_idx;
  logic [BLOCK_W-1:0] r_pack_buf;
  logic [MODE_W-1:0]  r_mode;
  logic               r_ovf, r_unf;

  logic               w_wr, w_rd, w_din_wr, w_dout_rd, w_ctrl_wr;
  logic               w_final, w_in_full, w_out_empty;
  logic               w_ovf_evt, w_unf_evt, w_in_push, w_out_pop;
  logic               w_clr_in, w_clr_out, w_clr_err;
  logic               w_issue, w_ret;
  logic [BLOCK_W-1:0] w_pack_next, w_out_head;
  logic [IEW-1:0]     w_in_head;
  logic [31:0]        w_out_word, w_rdata;

  assign w_wr      = PSEL && PENABLE && PWRITE;
  assign w_rd      = PSEL && PENABLE && !PWRITE;
  assign w_din_wr  = w_wr && (PADDR == A_DIN);
  assign w_dout_rd = w_rd && (PADDR == A_DOUT);
  assign w_ctrl_wr = w_wr && (PADDR == A_CTRL);
  assign w_clr_in  = w_ctrl_wr && PWDATA[8];
  assign w_clr_out = w_ctrl_wr && PWDATA[9];
  assign w_clr_err = w_ctrl_wr && PWDATA[10];

  assign w_final     = (r_pack_cnt == CW'(WORDS - 1));
  assign w_in_full   = (r_in_level == LW'(IN_DEPTH));
  assign w_out_empty = (r_out_level == '0);
  assign w_ovf_evt   = w_din_wr && w_final && w_in_full;
  assign w_in_push   = w_din_wr && w_final && !w_in_full;
  assign w_unf_evt   = w_dout_rd && w_out_empty;
  assign w_out_pop   = w_dout_rd && !w_out_empty && (r_unpack_idx == CW'(WORDS - 1));
  // Shift the new word in at the bottom so the first word ends up most significant
  assign w_pack_next = BLOCK_W'({r_pack_buf, PWDATA});

  // Issue only while the output FIFO can absorb every block already in flight
  assign w_in_head    = r_in_mem[r_in_rd];
  assign eng_in_valid = (r_in_level != '0) &&
                        (({1'b0, r_out_level} + {1'b0, r_inflight}) < (LW + 1)'(OUT_DEPTH));
  assign eng_in_data  = w_in_head[BLOCK_W-1:0];
  assign eng_in_mode  = w_in_head[IEW-1:BLOCK_W];
  assign w_issue      = eng_in_valid && eng_in_ready;
  assign w_ret        = eng_out_valid && (r_inflight != '0);

  assign w_out_head = r_out_mem[r_out_rd];
  always_comb begin
    w_out_word = '0;
    for (int i = 0; i < int'(WORDS); i++) begin
      if (r_unpack_idx == CW'(WORDS - 1 - i)) w_out_word = w_out_head[i*32 +: 32];
    end
  end

`ifdef APB_BRIDGE_IRQ_EN
  logic [1:0] r_irq_en, r_irq_stat;
  logic [1:0] w_irq_set;
  assign w_irq_set = {w_ovf_evt || w_unf_evt, w_ret && w_out_empty};
  assign irq       = |(r_irq_stat & r_irq_en);
`endif

  always_comb begin
    w_rdata = '0;
    case (PADDR)
      A_DOUT:  w_rdata = w_out_empty ? 32'd0 : w_out_word;
      A_CTRL:  w_rdata = 32'(r_mode);
      A_STAT:  w_rdata = {12'd0, r_unf, r_ovf, w_out_empty, w_in_full, r_out_level, r_in_level};
`ifdef APB_BRIDGE_IRQ_EN
      A_IEN:   w_rdata = 32'(r_irq_en);
      A_ISTAT: w_rdata = 32'(r_irq_stat);
`endif
      default: w_rdata = '0;
    endcase
  end

  assign PREADY  = 1'b1;
  assign PRDATA  = (w_rd && !PRESET) ? w_rdata : 32'd0;
  assign PSLVERR = !PRESET && (w_ovf_evt || w_unf_evt);

  // FIFO storage needs no reset; validity is tracked by the levels
  always_ff @(posedge PCLK) begin
    if (w_in_push) r_in_mem[r_in_wr]   <= {r_mode, w_pack_next};
    if (w_ret)     r_out_mem[r_out_wr] <= eng_out_data;
  end

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      r_in_wr <= '0; r_in_rd <= '0; r_out_wr <= '0; r_out_rd <= '0;
      r_in_level <= '0; r_out_level <= '0; r_inflight <= '0;
      r_pack_cnt <= '0; r_unpack_idx <= '0; r_pack_buf <= '0;
      r_mode <= '0; r_ovf <= 1'b0; r_unf <= 1'b0;
`ifdef APB_BRIDGE_IRQ_EN
      r_irq_en <= '0; r_irq_stat <= '0;
`endif
    end else begin
      if (w_clr_in) begin
        r_pack_cnt <= '0;
        r_pack_buf <= '0;
        r_in_rd    <= r_in_wr;
        r_in_level <= '0;
      end else begin
        if (w_din_wr && !w_ovf_evt) begin
          r_pack_buf <= w_pack_next;
          r_pack_cnt <= w_final ? '0 : r_pack_cnt + CW'(1);
        end
        if (w_in_push) r_in_wr <= (r_in_wr == IAW'(IN_DEPTH - 1)) ? '0 : r_in_wr + IAW'(1);
        if (w_issue)   r_in_rd <= (r_in_rd == IAW'(IN_DEPTH - 1)) ? '0 : r_in_rd + IAW'(1);
        if (w_in_push && !w_issue)      r_in_level <= r_in_level + LW'(1);
        else if (!w_in_push && w_issue) r_in_level <= r_in_level - LW'(1);
      end

      if (w_issue && !w_ret)      r_inflight <= r_inflight + LW'(1);
      else if (!w_issue && w_ret) r_inflight <= r_inflight - LW'(1);

      // A clear drops queued results but a result landing this cycle survives it
      if (w_ret) r_out_wr <= (r_out_wr == OAW'(OUT_DEPTH - 1)) ? '0 : r_out_wr + OAW'(1);
      if (w_clr_out) begin
        r_out_rd     <= r_out_wr;
        r_out_level  <= w_ret ? LW'(1) : '0;
        r_unpack_idx <= '0;
      end else begin
        if (w_out_pop) r_out_rd <= (r_out_rd == OAW'(OUT_DEPTH - 1)) ? '0 : r_out_rd + OAW'(1);
        if (w_ret && !w_out_pop)      r_out_level <= r_out_level + LW'(1);
        else if (!w_ret && w_out_pop) r_out_level <= r_out_level - LW'(1);
        if (w_dout_rd && !w_out_empty) r_unpack_idx <= w_out_pop ? '0 : r_unpack_idx + CW'(1);
      end

      if (w_ctrl_wr) r_mode <= PWDATA[MODE_W-1:0];
      if (w_clr_err) begin
        r_ovf <= 1'b0;
        r_unf <= 1'b0;
      end else begin
        if (w_ovf_evt) r_ovf <= 1'b1;
        if (w_unf_evt) r_unf <= 1'b1;
      end

`ifdef APB_BRIDGE_IRQ_EN
      if (w_wr && (PADDR == A_IEN)) r_irq_en <= PWDATA[1:0];
      if (w_wr && (PADDR == A_ISTAT)) r_irq_stat <= (r_irq_stat & ~PWDATA[1:0]) | w_irq_set;
      else                            r_irq_stat <= r_irq_stat | w_irq_set;
`endif
    end
  end

endmodule

// File: tb/tb_apb_cipher_bridge.sv
// Directed bench for apb_cipher_bridge: APB driver, echo engine model and block scoreboards.
module tb_apb_cipher_bridge;

  localparam int unsigned OUT_DEPTH = 4;

  logic        PCLK = 1'b0;
  logic        PRESET = 1'b1;
  logic [2:0]  PADDR = '0;
  logic        PSEL = 1'b0, PENABLE = 1'b0, PWRITE = 1'b0;
  logic [31:0] PWDATA = '0;
  logic        PREADY, PSLVERR;
  logic [31:0] PRDATA;
  logic        eng_in_valid, eng_in_ready = 1'b0;
  logic [63:0] eng_in_data;
  logic [2:0]  eng_in_mode;
  logic        eng_out_valid;
  logic [63:0] eng_out_data;
`ifdef APB_BRIDGE_IRQ_EN
  logic        irq;
`endif

  logic        man_v = 1'b0;
  logic [63:0] man_d = '0;
  logic        echo_en = 1'b0;
  logic        s1_v, s2_v, echo_v;
  logic [63:0] s1_d, s2_d, echo_d;

  logic [66:0] iss_q[$];
  logic [66:0] got_q[$];
  logic [31:0] rd_q[$];
  int          fire_cnt = 0, blocks_read = 0, max_outst = 0;
  int          n_cmp = 0, n_bad = 0;

  always #5 PCLK = ~PCLK;

  assign eng_out_valid = man_v | echo_v;
  assign eng_out_data  = man_v ? man_d : echo_d;

  apb_cipher_bridge #(.BLOCK_W(64), .IN_DEPTH(4), .OUT_DEPTH(OUT_DEPTH), .MODE_W(3)) dut (
    .PCLK(PCLK), .PRESET(PRESET), .PADDR(PADDR), .PSEL(PSEL), .PENABLE(PENABLE),
    .PWRITE(PWRITE), .PWDATA(PWDATA), .PREADY(PREADY), .PRDATA(PRDATA), .PSLVERR(PSLVERR),
    .eng_in_valid(eng_in_valid), .eng_in_ready(eng_in_ready), .eng_in_data(eng_in_data),
    .eng_in_mode(eng_in_mode), .eng_out_valid(eng_out_valid), .eng_out_data(eng_out_data)
`ifdef APB_BRIDGE_IRQ_EN
    , .irq(irq)
`endif
  );

  // Mid-cycle issue monitor plus an echo engine returning each block two cycles after issue
  always @(negedge PCLK) begin
    if (PRESET) begin
      s1_v <= 1'b0; s2_v <= 1'b0; echo_v <= 1'b0;
      s1_d <= '0;   s2_d <= '0;   echo_d <= '0;
    end else begin
      if (eng_in_valid && eng_in_ready) begin
        got_q.push_back({eng_in_mode, eng_in_data});
        fire_cnt <= fire_cnt + 1;
        if (fire_cnt + 1 - blocks_read > max_outst) max_outst <= fire_cnt + 1 - blocks_read;
      end
      s1_v <= echo_en && eng_in_valid && eng_in_ready;
      s1_d <= eng_in_data;
      s2_v <= s1_v; s2_d <= s1_d;
      echo_v <= s2_v; echo_d <= s2_d;
    end
  end

  task automatic chk(input string tag, input logic [66:0] obs, input logic [66:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic apb(input logic wr, input logic [2:0] a, input logic [31:0] d,
                     output logic [31:0] rd, output logic err);
    @(posedge PCLK); #2;
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = wr; PADDR = a; PWDATA = d;
    @(posedge PCLK); #2;
    PENABLE = 1'b1;
    @(negedge PCLK);
    rd = PRDATA; err = PSLVERR;
    @(posedge PCLK); #2;
    PSEL = 1'b0; PENABLE = 1'b0;
  endtask

  task automatic wr_reg(input logic [2:0] a, input logic [31:0] d);
    logic [31:0] rdv; logic errv;
    apb(1'b1, a, d, rdv, errv);
  endtask

  task automatic rd_chk(input logic [2:0] a, input logic [31:0] exp, input string tag);
    logic [31:0] rdv; logic errv;
    apb(1'b0, a, 32'd0, rdv, errv);
    chk(tag, 67'(rdv), 67'(exp));
  endtask

  task automatic put_block(input logic [31:0] w0, input logic [31:0] w1, input logic [2:0] mode,
                           input logic drop, input logic echo, input string tag);
    logic [31:0] rdv; logic errv;
    apb(1'b1, 3'd0, w0, rdv, errv);
    apb(1'b1, 3'd0, w1, rdv, errv);
    chk({tag, "_err"}, 67'(errv), 67'(drop));
    if (!drop) begin
      iss_q.push_back({mode, w0, w1});
      if (echo) begin
        rd_q.push_back(w0);
        rd_q.push_back(w1);
      end
    end
  endtask

  task automatic check_issues(input int n, input int cycles, input string tag);
    repeat (cycles) @(negedge PCLK);
    chk({tag, "_count"}, 67'(got_q.size()), 67'(n));
    for (int k = 0; k < n && got_q.size() != 0 && iss_q.size() != 0; k++)
      chk(tag, got_q.pop_front(), iss_q.pop_front());
  endtask

  task automatic read_words(input int nw, input string tag);
    logic [31:0] rdv, exp; logic errv;
    for (int k = 0; k < nw; k++) begin
      apb(1'b0, 3'd1, 32'd0, rdv, errv);
      exp = (rd_q.size() != 0) ? rd_q.pop_front() : 32'hDEAD_BEEF;
      chk(tag, 67'(rdv), 67'(exp));
      if (k % 2 == 1) blocks_read++;
    end
  endtask

  initial begin
    logic [31:0] rdv;
    logic        errv, seen;

    // Reset: outputs quiet even with a read access presented
    PSEL = 1'b1; PENABLE = 1'b1; PWRITE = 1'b0; PADDR = 3'd3;
    repeat (3) @(negedge PCLK);
    chk("rst_prdata", 67'(PRDATA), 67'(0));
    chk("rst_pslverr", 67'(PSLVERR), 67'(0));
    chk("rst_in_valid", 67'(eng_in_valid), 67'(0));
    chk("pready", 67'(PREADY), 67'(1));
`ifdef APB_BRIDGE_IRQ_EN
    chk("rst_irq", 67'(irq), 67'(0));
`endif
    @(posedge PCLK); #2;
    PSEL = 1'b0; PENABLE = 1'b0; PRESET = 1'b0;
    rd_chk(3'd3, 32'h0002_0000, "status_idle");

    // Packing and issue of one block with mode 5
    wr_reg(3'd2, 32'd5);
    put_block(32'h0123_4567, 32'h89AB_CDEF, 3'd5, 1'b0, 1'b0, "blkA");
    @(negedge PCLK);
    chk("A_valid", 67'(eng_in_valid), 67'(1));
    chk("A_data", 67'(eng_in_data), 67'(64'h0123_4567_89AB_CDEF));
    chk("A_mode", 67'(eng_in_mode), 67'(5));
    @(posedge PCLK); #2; eng_in_ready = 1'b1;
    check_issues(1, 4, "A_issue");

    // Engine result and unpacked readback
    @(posedge PCLK); #2;
    man_v = 1'b1; man_d = 64'hFEDC_BA98_7654_3210;
    rd_q.push_back(32'hFEDC_BA98); rd_q.push_back(32'h7654_3210);
    @(posedge PCLK); #2; man_v = 1'b0;
    rd_chk(3'd3, 32'h0000_0100, "status_out1");
    read_words(2, "A_out");
    rd_chk(3'd3, 32'h0002_0000, "status_drained");

    // Input overflow with the engine stalled
    @(posedge PCLK); #2; eng_in_ready = 1'b0;
    for (int i = 0; i < 5; i++)
      put_block(32'h1111_0000 + 32'(i), 32'h2222_0000 + 32'(i), 3'd5, i == 4, 1'b1,
                $sformatf("ovf%0d", i));
    rd_chk(3'd3, 32'h0007_0004, "status_ovf");
    wr_reg(3'd2, 32'h0000_0405);
    rd_chk(3'd3, 32'h0003_0004, "status_clr_ovf");
    rd_chk(3'd2, 32'h0000_0005, "ctrl_rb");

    // Credit limit: echo engine, no reads, only OUT_DEPTH blocks may be issued
    @(posedge PCLK); #2; echo_en = 1'b1; eng_in_ready = 1'b1;
    check_issues(4, 20, "C_issue");
    rd_chk(3'd3, 32'h0000_0400, "status_out4");
    // The dropped final word left the packer one word in; resending it completes block 4
    apb(1'b1, 3'd0, 32'h2222_0004, rdv, errv);
    chk("retry_err", 67'(errv), 67'(0));
    iss_q.push_back({3'd5, 32'h1111_0004, 32'h2222_0004});
    rd_q.push_back(32'h1111_0004); rd_q.push_back(32'h2222_0004);
    put_block(32'h1111_0005, 32'h2222_0005, 3'd5, 1'b0, 1'b1, "blk5");
    check_issues(0, 10, "C_held");
    rd_chk(3'd3, 32'h0000_0402, "status_held");
    read_words(2, "C_out0");
    check_issues(1, 10, "C_one_more");
    rd_chk(3'd3, 32'h0000_0401, "status_refill");
    read_words(10, "C_out");
    check_issues(1, 2, "C_last");
    rd_chk(3'd3, 32'h0002_0000, "status_C_done");
    chk("credit_max", 67'(max_outst), 67'(OUT_DEPTH));

    // Output underflow and error clear
    apb(1'b0, 3'd1, 32'd0, rdv, errv);
    chk("unf_data", 67'(rdv), 67'(0));
    chk("unf_err", 67'(errv), 67'(1));
    rd_chk(3'd3, 32'h000A_0000, "status_unf");
    wr_reg(3'd2, 32'h0000_0405);
    rd_chk(3'd3, 32'h0002_0000, "status_clr_unf");
    wr_reg(3'd6, 32'hFFFF_FFFF);
    rd_chk(3'd6, 32'h0000_0000, "reg6");

`ifdef APB_BRIDGE_IRQ_EN
    wr_reg(3'd5, 32'h3);
    wr_reg(3'd4, 32'h1);
    @(negedge PCLK);
    chk("irq_idle", 67'(irq), 67'(0));
    put_block(32'hA5A5_0001, 32'h5A5A_0002, 3'd5, 1'b0, 1'b1, "irqblk");
    seen = 1'b0;
    for (int k = 0; k < 30 && !seen; k++) begin
      @(negedge PCLK); #1;
      seen = eng_out_valid;
    end
    chk("irq_result_seen", 67'(seen), 67'(1));
    chk("irq_pre", 67'(irq), 67'(0));
    @(posedge PCLK); #1;
    chk("irq_rise", 67'(irq), 67'(1));
    wr_reg(3'd5, 32'h1);
    chk("irq_w1c", 67'(irq), 67'(0));
    rd_chk(3'd5, 32'h0, "istat_cleared");
    check_issues(1, 2, "irq_issue");
    read_words(2, "irq_out");
`else
    wr_reg(3'd4, 32'hFFFF_FFFF);
    wr_reg(3'd5, 32'hFFFF_FFFF);
    rd_chk(3'd4, 32'h0, "ien_absent");
    rd_chk(3'd5, 32'h0, "istat_absent");
`endif

    // Reset mid-transfer discards the partial word and the CTRL mode
    wr_reg(3'd0, 32'hDEAD_0000);
    @(posedge PCLK); #2; PRESET = 1'b1;
    @(posedge PCLK); #2; PRESET = 1'b0;
    rd_chk(3'd2, 32'h0, "ctrl_after_rst");
    rd_chk(3'd3, 32'h0002_0000, "status_after_rst");
    put_block(32'h1357_9BDF, 32'h2468_ACE0, 3'd0, 1'b0, 1'b1, "post_rst");
    check_issues(1, 8, "post_rst_issue");
    read_words(2, "post_rst_out");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: observed no finish, expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/apb_cipher_bridge.md
APB_CIPHER_BRIDGE -- requirements
Module: apb_cipher_bridge

Interface
REQ-001 Parameter BLOCK_W, default 64: cipher block width in bits; multiple of 32, at least 32.
REQ-002 Parameter IN_DEPTH, default 4: input block FIFO depth; power of two, at most 128.
REQ-003 Parameter OUT_DEPTH, default 4: output block FIFO depth; power of two, at most 128.
REQ-004 Parameter MODE_W, default 3: width of the per-block engine mode field.
REQ-005 PCLK  in  1  single clock; all state changes on its rising edge.
REQ-006 PRESET  in  1  asynchronous, active-high reset.
REQ-007 PADDR  in  3  register index; PSEL, PENABLE, PWRITE  in  1 each; PWDATA  in  32.
REQ-008 PREADY  out  1  tied to 1; PRDATA  out  32  read data; PSLVERR  out  1  access error.
REQ-009 eng_in_valid  out  1 / eng_in_ready  in  1 / eng_in_data  out  BLOCK_W / eng_in_mode  out  MODE_W: block issue to the engine.
REQ-010 eng_out_valid  in  1 / eng_out_data  in  BLOCK_W: engine result; no backpressure.
REQ-011 irq  out  1  level interrupt; present only when the REQ-026 macro is defined.

Function
REQ-012 An access completes on the edge where PSEL=1 and PENABLE=1. Side effects occur only on that edge. PRDATA and PSLVERR are valid combinationally during the access phase and are 0 otherwise.
REQ-013 Register map:
- 0 DATA_IN (W)
- 1 DATA_OUT (R)
- 2 CTRL (RW): [MODE_W-1:0] mode; bit8 clr_in, bit9 clr_out, bit10 clr_err, all write-only pulses that read back 0.
- 3 STATUS (R): [7:0] in level, [15:8] out level, [16] in_full, [17] out_empty, [18] ovf, [19] unf.
- 4 IRQ_EN (RW)
- 5 IRQ_STAT (R, write-1-to-clear)
- Indices 6 and 7 read 0; writes to them are ignored.
REQ-014 DATA_IN packing: BLOCK_W/32 writes form one block, first word in the most significant position. On the final word, the block and the current CTRL mode are pushed together into the input FIFO.
REQ-015 A final-word DATA_IN write while the input FIFO is full is dropped. It asserts PSLVERR, sets ovf, and leaves the packer word count unchanged.
REQ-016 Issue rule: eng_in_valid=1 exactly when the input FIFO is non-empty and out_level + inflight < OUT_DEPTH. eng_in_data and eng_in_mode come from the FIFO head. Pop and inflight increment occur on valid&&ready.
REQ-017 eng_out_valid pushes eng_out_data into the output FIFO and decrements inflight. If inflight=0 the beat is ignored. Issue and return in the same cycle leave inflight unchanged.
REQ-018 DATA_OUT read unpacking: words are returned most significant first. The FIFO head pops after word BLOCK_W/32. The unpack index wraps to 0.
REQ-019 A DATA_OUT read with the output FIFO empty returns 0, asserts PSLVERR, sets unf, and does not advance the index.
REQ-020 A push and a pop on the same FIFO in one cycle leave its level unchanged. Full and empty flags are exact for every depth.
REQ-021 clr_in empties the input FIFO and zeroes the packer. clr_out empties the output FIFO and zeroes the unpack index. Neither changes inflight; in-flight results still land after a clear. clr_err zeroes ovf and unf.
REQ-022 The credit rule of REQ-016 guarantees no engine result is ever lost. A bench assertion shall check out_level + inflight <= OUT_DEPTH.

Reset
REQ-023 While PRESET=1, and asynchronously on its assertion:
- FIFOs empty, packer, unpack index and inflight zero;
- CTRL, IRQ_EN, IRQ_STAT, ovf and unf zero;
- eng_in_valid=0, PRDATA=0, PSLVERR=0, irq=0.
REQ-024 Reset asserted mid-transfer discards all partial words and queued blocks. Engine results that arrive after reset are ignored because inflight is 0.
REQ-025 The first access is accepted on the first PCLK edge after PRESET deasserts.

Configuration
REQ-026 With APB_BRIDGE_IRQ_EN defined:
- IRQ_STAT bit0 is set when an output block becomes available (out level goes 0 to 1); bit1 is set when ovf or unf is set.
- irq = |(IRQ_STAT & IRQ_EN[1:0]).
- Without the macro, the irq port is absent, registers 4 and 5 read 0, and writes to them are ignored.

Verification
REQ-027 The bench shall cover the following directed scenarios:
- Reset, then write DATA_IN 0x01234567 and 0x89ABCDEF with CTRL mode=5 -> eng_in_data=0x0123456789ABCDEF, eng_in_mode=5 on the next cycle.
- Engine returns 0xFEDCBA9876543210 -> STATUS[15:8]=1; two DATA_OUT reads return 0xFEDCBA98 then 0x76543210; STATUS[17]=1.
- eng_in_ready held 0, write 5 blocks with IN_DEPTH=4 -> 5th final word gives PSLVERR=1 and STATUS[18]=1.
- Engine echoes input with 2-cycle latency, 6 blocks queued, no reads, OUT_DEPTH=4 -> exactly 4 issued, no loss; each DATA_OUT block read issues one more.
- Read DATA_OUT when empty -> PRDATA=0, PSLVERR=1, unf=1. Write CTRL bit10 -> STATUS[19:18]=0.
- Macro on, IRQ_EN=1 -> irq rises the cycle after the first result lands; writing 1 to IRQ_STAT bit0 drops irq.
